fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 205 ++++++++++++++++++++
 tb/tb_fifo_wr_arb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter that lets one of NUM_REQ burst sources at a
// time write {source id, payload} words into a downstream FIFO. A grant is held
// until the owner's last beat, so bursts are never interleaved in the FIFO.
// Optional watchdog: define FIFO_WR_ARB_WATCHDOG_EN to release a grant whose
// owner has shown no valid beat for TIMEOUT cycles (pulses timeout_err).
module fifo_wr_arb #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           fifo_full,
  output logic                           fifo_wr_en,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_din,
  output logic [ID_WIDTH-1:0]            grant_id,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int OUT_W = ID_WIDTH + DATA_WIDTH;

  // Reject configurations the arbiter cannot represent.
  if (NUM_REQ < 2 || NUM_REQ > (1 << ID_WIDTH) || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_err
    $error("fifo_wr_arb: parameter out of range");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [OUT_W-1:0]    din_q, din_d;

  logic [ID_WIDTH-1:0]   pick_id;
  logic                  pick_found;
  int                    pick_idx;
  logic                  valid_g;
  logic                  last_g;
  logic [DATA_WIDTH-1:0] data_g;
  logic                  xfer;
  logic [ID_WIDTH-1:0]   next_ptr;

`ifdef FIFO_WR_ARB_WATCHDOG_EN
  localparam int WD_W = 16;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  // Owner's request signals and the beat-transfer condition.
  always_comb begin
    valid_g  = req_valid[grant_id_q];
    last_g   = req_last[grant_id_q];
    data_g   = req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
    xfer     = (state_q == S_GRANT) && valid_g && !fifo_full;
    if (grant_id_q == ID_WIDTH'(NUM_REQ - 1)) begin
      next_ptr = {ID_WIDTH{1'b0}};
    end else begin
      next_ptr = grant_id_q + ID_WIDTH'(1);
    end
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_id    = {ID_WIDTH{1'b0}};
    pick_found = 1'b0;
    pick_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pick_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!pick_found && req_valid[pick_idx]) begin
        pick_found = 1'b1;
        pick_id    = pick_idx[ID_WIDTH-1:0];
      end else begin
        pick_found = pick_found;
      end
    end
  end

  // Only the owner sees ready, and only while the FIFO has room.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state_q == S_GRANT) && (grant_id_q == ID_WIDTH'(i))) begin
        req_ready[i] = !fifo_full;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // FIFO write port: the word goes out in the transfer cycle, else hold last word.
  always_comb begin
    if (xfer) begin
      din_d = {grant_id_q, data_g};
    end else begin
      din_d = din_q;
    end
    fifo_din   = din_d;
    fifo_wr_en = xfer;
  end

  // Next-state logic: arbitrate in IDLE, stream the owner's burst in GRANT.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
`ifdef FIFO_WR_ARB_WATCHDOG_EN
    wd_cnt_d   = wd_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef FIFO_WR_ARB_WATCHDOG_EN
        wd_cnt_d = {WD_W{1'b0}};
`endif
        if (pick_found) begin
          state_d    = S_GRANT;
          grant_id_d = pick_id;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (xfer) begin
`ifdef FIFO_WR_ARB_WATCHDOG_EN
          wd_cnt_d = {WD_W{1'b0}};
`endif
          if (last_g) begin
            state_d  = S_IDLE;
            rr_ptr_d = next_ptr;
          end else begin
            state_d = S_GRANT;
          end
        end
`ifdef FIFO_WR_ARB_WATCHDOG_EN
        else if (!valid_g) begin
          // Owner silent this cycle; the TIMEOUT-th silent cycle releases it.
          if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
            state_d   = S_IDLE;
            rr_ptr_d  = next_ptr;
            timeout_d = 1'b1;
            wd_cnt_d  = {WD_W{1'b0}};
          end else begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
          end
        end else begin
          // FIFO-full stall: owner is alive, counter neither runs nor clears.
          wd_cnt_d = wd_cnt_q;
        end
`else
        else begin
          state_d = S_GRANT;
        end
`endif
      end
      default: begin
        state_d    = S_IDLE;
        grant_id_d = {ID_WIDTH{1'b0}};
      end
    endcase
  end

  // State registers; reset abandons any burst and restarts arbitration at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_id_q <= {ID_WIDTH{1'b0}};
      rr_ptr_q   <= {ID_WIDTH{1'b0}};
      din_q      <= {OUT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      din_q      <= din_d;
    end
  end

`ifdef FIFO_WR_ARB_WATCHDOG_EN
  // Watchdog counter and its one-cycle release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= {WD_W{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign busy     = (state_q == S_GRANT);
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: inputs change on the falling edge, outputs
// are checked 1 ns later, the arbiter samples on the rising edge.
module tb_fifo_wr_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [17:0] fifo_din;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int errors;
  int checks;
  int wd_seen;

  fifo_wr_arb #(
    .DATA_WIDTH(16),
    .NUM_REQ   (4),
    .ID_WIDTH  (2),
    .TIMEOUT   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_data(input int i, input logic [15:0] d);
    req_data[i*16 +: 16] = d;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    wd_seen   = 0;
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    req_data  = 64'h0;
    fifo_full = 1'b0;

    // Reset state
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("rst_grant", {30'd0, grant_id}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    chk("rst_din", {14'd0, fifo_din}, 32'd0);

    // 3-beat burst from requester 2
    tick(); rst_n = 1'b1;
    tick(); req_valid = 4'b0100; set_data(2, 16'h00A1); #1;
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    chk("t1_idle_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("t1_idle_ready", {28'd0, req_ready}, 32'd0);
    tick(); #1;
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_grant", {30'd0, grant_id}, 32'd2);
    chk("t1_ready", {28'd0, req_ready}, 32'h4);
    chk("t1_wr_en_a1", {31'd0, fifo_wr_en}, 32'd1);
    chk("t1_din_a1", {14'd0, fifo_din}, 32'h200A1);
    tick(); set_data(2, 16'h00A2); #1;
    chk("t1_din_a2", {14'd0, fifo_din}, 32'h200A2);
    chk("t1_wr_en_a2", {31'd0, fifo_wr_en}, 32'd1);
    tick(); set_data(2, 16'h00A3); req_last = 4'b0100; #1;
    chk("t1_din_a3", {14'd0, fifo_din}, 32'h200A3);
    chk("t1_wr_en_a3", {31'd0, fifo_wr_en}, 32'd1);
    tick(); req_valid = 4'b0000; req_last = 4'b0000; #1;
    chk("t1_end_busy", {31'd0, busy}, 32'd0);
    chk("t1_end_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("t1_end_din_hold", {14'd0, fifo_din}, 32'h200A3);

    // Round robin with all four requesting single-beat bursts
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_data(i, 16'h0010 + 16'(i));
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      #1;
      chk("rr_idle_busy", {31'd0, busy}, 32'd0);
      chk("rr_idle_wr_en", {31'd0, fifo_wr_en}, 32'd0);
      tick(); #1;
      chk("rr_busy", {31'd0, busy}, 32'd1);
      chk("rr_grant", {30'd0, grant_id}, 32'(b % 4));
      chk("rr_wr_en", {31'd0, fifo_wr_en}, 32'd1);
      chk("rr_din", {14'd0, fifo_din}, (32'(b % 4) << 16) | (32'h10 + 32'(b % 4)));
      tick();
    end

    // Requester 1 burst with a 10-cycle FIFO-full stall
    req_valid = 4'b0010; req_last = 4'b0000; set_data(1, 16'h00B1); #1;
    chk("t3_idle_busy", {31'd0, busy}, 32'd0);
    tick(); #1;
    chk("t3_grant", {30'd0, grant_id}, 32'd1);
    chk("t3_din_b1", {14'd0, fifo_din}, 32'h100B1);
    for (int c = 0; c < 10; c++) begin
      tick(); set_data(1, 16'h00B2); fifo_full = 1'b1; #1;
      chk("t3_stall_ready", {28'd0, req_ready}, 32'd0);
      chk("t3_stall_wr_en", {31'd0, fifo_wr_en}, 32'd0);
      chk("t3_stall_busy", {31'd0, busy}, 32'd1);
      chk("t3_stall_timeout", {31'd0, timeout_err}, 32'd0);
    end
    tick(); fifo_full = 1'b0; #1;
    chk("t3_ready", {28'd0, req_ready}, 32'h2);
    chk("t3_wr_en_b2", {31'd0, fifo_wr_en}, 32'd1);
    chk("t3_din_b2", {14'd0, fifo_din}, 32'h100B2);
    tick(); set_data(1, 16'h00B3); req_last = 4'b0010; #1;
    chk("t3_din_b3", {14'd0, fifo_din}, 32'h100B3);
    tick(); req_valid = 4'b0000; req_last = 4'b0000; #1;
    chk("t3_end_busy", {31'd0, busy}, 32'd0);
    chk("t3_end_timeout", {31'd0, timeout_err}, 32'd0);

    // Requester 3 granted, then goes silent
    tick(); req_valid = 4'b1000; set_data(3, 16'h00E3); #1;
    chk("t4_idle_busy", {31'd0, busy}, 32'd0);
    tick(); req_valid = 4'b0000; #1;
    chk("t4_busy", {31'd0, busy}, 32'd1);
    chk("t4_grant", {30'd0, grant_id}, 32'd3);
    chk("t4_wr_en", {31'd0, fifo_wr_en}, 32'd0);
`ifdef FIFO_WR_ARB_WATCHDOG_EN
    for (int c = 1; c <= 20; c++) begin
      tick(); #1;
      if (timeout_err === 1'b1) begin
        wd_seen = c;
        break;
      end
    end
    chk("t4_wd_latency", 32'(wd_seen), 32'd8);
    req_valid = 4'b0011; req_last = 4'b0011; set_data(0, 16'h00D0); #1;
    chk("t4_wd_busy", {31'd0, busy}, 32'd0);
    tick(); #1;
    chk("t4_wd_pulse_len", {31'd0, timeout_err}, 32'd0);
    chk("t4_wd_next_grant", {30'd0, grant_id}, 32'd0);
    chk("t4_wd_next_busy", {31'd0, busy}, 32'd1);
    chk("t4_wd_next_din", {14'd0, fifo_din}, 32'h000D0);
    tick(); req_valid = 4'b0000; req_last = 4'b0000; #1;
    chk("t4_wd_end_busy", {31'd0, busy}, 32'd0);
`else
    for (int c = 0; c < 20; c++) begin
      tick(); #1;
      chk("t4_hold_timeout", {31'd0, timeout_err}, 32'd0);
      chk("t4_hold_busy", {31'd0, busy}, 32'd1);
      chk("t4_hold_grant", {30'd0, grant_id}, 32'd3);
    end
    tick(); req_valid = 4'b1000; req_last = 4'b1000; #1;
    chk("t4_hold_wr_en", {31'd0, fifo_wr_en}, 32'd1);
    chk("t4_hold_din", {14'd0, fifo_din}, 32'h300E3);
    tick(); req_valid = 4'b0000; req_last = 4'b0000; #1;
    chk("t4_hold_end_busy", {31'd0, busy}, 32'd0);
`endif

    // Reset in the middle of a requester-2 burst
    tick(); req_valid = 4'b0100; set_data(2, 16'h00C1); #1;
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    tick(); #1;
    chk("t5_grant", {30'd0, grant_id}, 32'd2);
    chk("t5_din_c1", {14'd0, fifo_din}, 32'h200C1);
    tick(); set_data(2, 16'h00C2); rst_n = 1'b0; #1;
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_ready", {28'd0, req_ready}, 32'd0);
    chk("t5_rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("t5_rst_grant", {30'd0, grant_id}, 32'd0);
    chk("t5_rst_timeout", {31'd0, timeout_err}, 32'd0);
    chk("t5_rst_din", {14'd0, fifo_din}, 32'd0);
    tick(); req_valid = 4'b0110; rst_n = 1'b1; #1;
    chk("t5_rel_busy", {31'd0, busy}, 32'd0);
    tick(); #1;
    chk("t5_post_busy", {31'd0, busy}, 32'd1);
    chk("t5_post_grant", {30'd0, grant_id}, 32'd1);
    chk("t5_post_ready", {28'd0, req_ready}, 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
